// File: rtl/vram_write_arbiter.sv
// -----------------------------------------------------------------------------
// vram_write_arbiter
//
// Arbitrates the single framebuffer (VRAM) access port between NCH channels.
// Channel 0 is the background (display scan-out) channel and owns the port by
// default. Channels 1..NCH-1 are writers. They may take the port only while a
// free-running frame-period counter is inside the writer window
// (cnt >= WIN_START). Among the eligible writers (req & ch_en), one winner is
// picked per cycle. Every port output is driven from a register, so there is
// no combinational path from the inputs to the outputs.
//
// Build option:
//   VRAM_ARB_ROUND_ROBIN_EN  defined   -> round-robin among writers; the search
//                                         starts after the last granted writer.
//                            undefined -> fixed priority; the lowest writer
//                                         index wins.
//
// Ports:
//   clk        in   1        system clock
//   rstn       in   1        asynchronous active-low reset
//   ch_en      in   NCH      per-channel enable (bit 0 ignored)
//   req        in   NCH      per-channel request
//   ch_addr    in   NCH*AW   channel i address at [i*AW +: AW]
//   ch_dwrite  in   NCH*DW   channel i write data at [i*DW +: DW]
//   ch_wr      in   NCH      per-channel write strobe
//   ack        out  NCH      grant, one-hot or zero, registered
//   addr       out  AW       VRAM address, registered
//   dwrite     out  DW       VRAM write data, registered
//   wr         out  1        VRAM write enable, registered
//   sel        out  SW       index of the channel on the port, registered
//   in_window  out  1        the command on the port was issued in the window
// -----------------------------------------------------------------------------
module vram_write_arbiter #(
    parameter int NCH       = 4,
    parameter int AW        = 19,
    parameter int DW        = 16,
    parameter int CNT_W     = 20,
    parameter int PERIOD    = 1048576,
    parameter int WIN_START = 181440
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*AW-1:0]      ch_addr,
    input  logic [NCH*DW-1:0]      ch_dwrite,
    input  logic [NCH-1:0]         ch_wr,
    output logic [NCH-1:0]         ack,
    output logic [AW-1:0]          addr,
    output logic [DW-1:0]          dwrite,
    output logic                   wr,
    output logic [$clog2(NCH)-1:0] sel,
    output logic                   in_window
);

    // NCH is at least 2, so clog2 already yields a width of at least 1.
    localparam int                SW          = $clog2(NCH);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_WIN     = CNT_W'(WIN_START);
    localparam logic [NCH-1:0]    WRITER_MASK = {{(NCH-1){1'b1}}, 1'b0};

    logic [CNT_W-1:0] r_cnt;
    logic [NCH-1:0]   r_ack;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_dwrite;
    logic             r_wr;
    logic [SW-1:0]    r_sel;
    logic             r_in_window;

    logic             w_win_open;
    logic             w_writer_grant;
    logic [NCH-1:0]   w_elig;
    logic [NCH-1:0]   w_ack_next;
    logic [SW-1:0]    w_pick;
    logic [SW-1:0]    w_winner;

    // Frame-period counter: 0..PERIOD-1, then wraps, which also closes the window.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so that every
        // always_ff samples the pre-edge values, whatever the evaluation order.
        if (!rstn) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_win_open     = (r_cnt >= CNT_WIN);
    assign w_elig         = req & ch_en & WRITER_MASK;
    assign w_writer_grant = w_win_open && (|w_elig);
    assign w_winner       = w_writer_grant ? w_pick : '0;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
    // Last granted writer (1..NCH-1). It resets to NCH-1 so that the first
    // search after reset starts at channel 1. It only moves on a writer grant,
    // so it survives window closures.
    logic [SW-1:0] r_last;

    // Scan writers last+1, last+2, ... wrapping from NCH-1 back to 1, and take
    // the first eligible one.
    function automatic logic [SW-1:0] rr_pick(input logic [NCH-1:0] elig,
                                              input logic [SW-1:0]  last);
        logic found;
        int   cand;
        rr_pick = SW'(1);
        found   = 1'b0;
        for (int k = 1; k < NCH; k++) begin
            cand = ((int'(last) - 1 + k) % (NCH - 1)) + 1;
            if (!found && elig[cand]) begin
                rr_pick = SW'(cand);
                found   = 1'b1;
            end
        end
    endfunction

    assign w_pick = rr_pick(w_elig, r_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= SW'(NCH - 1);
        end else if (w_writer_grant) begin
            r_last <= w_winner;
        end
    end
`else
    // Fixed priority: scanning downwards, the lowest eligible writer index is
    // the one left in the result.
    function automatic logic [SW-1:0] fp_pick(input logic [NCH-1:0] elig);
        fp_pick = '0;
        for (int i = NCH - 1; i >= 1; i--) begin
            if (elig[i]) begin
                fp_pick = SW'(i);
            end
        end
    endfunction

    assign w_pick = fp_pick(w_elig);
`endif

    // A writer grant always acks. When channel 0 holds the port, it is acked
    // only if it is actually requesting.
    always_comb begin
        // NOTE: a default is assigned first so that every path writes the whole
        // vector and no latch can be inferred.
        w_ack_next           = '0;
        w_ack_next[w_winner] = w_writer_grant ? 1'b1 : req[0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack       <= '0;
            r_addr      <= '0;
            r_dwrite    <= '0;
            r_wr        <= 1'b0;
            r_sel       <= '0;
            r_in_window <= 1'b0;
        end else begin
            r_ack       <= w_ack_next;
            r_addr      <= ch_addr[int'(w_winner)*AW +: AW];
            r_dwrite    <= ch_dwrite[int'(w_winner)*DW +: DW];
            r_wr        <= ch_wr[w_winner];
            r_sel       <= w_winner;
            r_in_window <= w_win_open;
        end
    end

    assign ack       = r_ack;
    assign addr      = r_addr;
    assign dwrite    = r_dwrite;
    assign wr        = r_wr;
    assign sel       = r_sel;
    assign in_window = r_in_window;

endmodule
